// File: rtl/dot_product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dot_product_accumulator                                                    |
// | Sums a stream of multiplier products into one saturated result per vector. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dot_product_accumulator #(
  parameter  int PROD_W  = 8,
  parameter  int ACC_W   = 16,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_sat,
  output logic              out_forced
);

  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);

  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic             sat_flag;

  logic             accept;
  logic             transfer;
  logic [ACC_W:0]   sum_ext;
  logic             clamp;
  logic [ACC_W-1:0] nxt;
  logic [LEN_W-1:0] cnt_n;
  logic             closing;

  // Stall only while a result is held and nobody is taking it.
  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && out_ready;

  // One guard bit catches overflow; a saturated acc re-clamps on every term.
  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(in_product);
  assign clamp   = sum_ext[ACC_W];
  assign nxt     = clamp ? ACC_MAX : sum_ext[ACC_W-1:0];
  assign cnt_n   = cnt + LEN_W'(1);
  assign closing = in_last || (cnt_n == LEN_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      if (closing) begin
        acc      <= '0;
        cnt      <= '0;
        sat_flag <= 1'b0;
      end else begin
        acc      <= nxt;
        cnt      <= cnt_n;
        sat_flag <= sat_flag || clamp;
      end
    end
  end

  // A closing beat reloads the result even while the previous one leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_len    <= '0;
      out_sat    <= 1'b0;
      out_forced <= 1'b0;
    end else if (accept && closing) begin
      out_valid  <= 1'b1;
      out_sum    <= nxt;
      out_len    <= cnt_n;
      out_sat    <= sat_flag || clamp;
      out_forced <= !in_last;
    end else if (transfer) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
`default_nettype none
// Bench for dot_product_accumulator: directed scenarios plus a randomized
// stream checked against a vector-level reference model.
module tb_dot_product_accumulator;

  localparam int MAX_LEN = 16;
  localparam int MAXV    = 65535;
  localparam int MAXV10  = 1023;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_product;
  logic       in_ready, out_valid, out_sat, out_forced;
  logic [15:0] out_sum;
  logic [4:0]  out_len;

  logic       s_valid, s_last, s_oready;
  logic [7:0] s_product;
  logic       s_iready, s_ovalid, s_sat, s_forced;
  logic [9:0] s_sum;
  logic [4:0] s_len;

  int checks = 0;
  int errors = 0;

  // Reference model: held result plus the terms of the open vector.
  int  vec[$];
  bit  m_ov;
  int  m_sum, m_len;
  bit  m_sat, m_forced;
  bit  exp_rdy, got_rdy;

  always #5 clk = ~clk;

  dot_product_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_len(out_len),
    .out_sat(out_sat), .out_forced(out_forced)
  );

  dot_product_accumulator #(.ACC_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_valid), .in_ready(s_iready), .in_product(s_product), .in_last(s_last),
    .out_valid(s_ovalid), .out_ready(s_oready), .out_sum(s_sum), .out_len(s_len),
    .out_sat(s_sat), .out_forced(s_forced)
  );

  task automatic model_clear();
    vec.delete();
    m_ov = 0; m_sum = 0; m_len = 0; m_sat = 0; m_forced = 0;
  endtask

  // Drives one cycle starting just after a rising edge; returns just after the next.
  task automatic drive(input logic v, input logic [7:0] p, input logic l, input logic r);
    int total;
    in_valid = v; in_product = p; in_last = l; out_ready = r;
    exp_rdy = !(m_ov && !r);
    #2;
    got_rdy = in_ready;
    @(posedge clk);
    if (m_ov && r) m_ov = 0;
    if (v && exp_rdy) begin
      vec.push_back(int'(p));
      if (l || vec.size() == MAX_LEN) begin
        total = 0;
        foreach (vec[i]) total += vec[i];
        m_sum    = (total > MAXV) ? MAXV : total;
        m_sat    = total > MAXV;
        m_len    = vec.size();
        m_forced = !l;
        m_ov     = 1;
        vec.delete();
      end
    end
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'd0 || out_len !== 5'd0 ||
        out_sat !== 1'b0 || out_forced !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b ov=%b sum=%0d len=%0d sat=%b frc=%b required 1 0 0 0 0 0",
               in_ready, out_valid, out_sum, out_len, out_sat, out_forced);
    end
  endtask

  task automatic test_normal();
    drive(1, 8'd225, 0, 1);
    drive(1, 8'd6, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL normal_early: out_valid=%b required 0", out_valid);
    end
    drive(1, 8'd1, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'd232 || out_len !== 5'd3 || out_sat !== 1'b0 ||
        out_forced !== 1'b0) begin
      errors++;
      $display("FAIL normal_vector: ov=%b sum=%0d len=%0d sat=%b frc=%b required 1 232 3 0 0",
               out_valid, out_sum, out_len, out_sat, out_forced);
    end
    drive(0, 8'd0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 16'd232) begin
      errors++;
      $display("FAIL normal_drain: ov=%b sum=%0d required 0 232", out_valid, out_sum);
    end
  endtask

  task automatic test_saturation();
    int total = 0;
    s_oready = 1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_product = 8'd225; s_last = (i == 4);
      total += 225;
      @(posedge clk); #1;
    end
    checks++;
    if (s_ovalid !== 1'b1 || s_sum !== 10'((total > MAXV10) ? MAXV10 : total) || s_sat !== 1'b1 ||
        s_len !== 5'd5 || s_forced !== 1'b0) begin
      errors++;
      $display("FAIL sat_vector: ov=%b sum=%0d sat=%b len=%0d frc=%b required 1 1023 1 5 0",
               s_ovalid, s_sum, s_sat, s_len, s_forced);
    end
    s_product = 8'd4; s_last = 0;
    @(posedge clk); #1;
    s_last = 1;
    @(posedge clk); #1;
    checks++;
    if (s_ovalid !== 1'b1 || s_sum !== 10'd8 || s_sat !== 1'b0 || s_len !== 5'd2) begin
      errors++;
      $display("FAIL sat_next_vector: ov=%b sum=%0d sat=%b len=%0d required 1 8 0 2",
               s_ovalid, s_sum, s_sat, s_len);
    end
    s_valid = 0; s_last = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_forced();
    for (int i = 0; i < 16; i++) drive(1, 8'd1, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'd16 || out_len !== 5'd16 || out_forced !== 1'b1 ||
        out_sat !== 1'b0) begin
      errors++;
      $display("FAIL forced_close: ov=%b sum=%0d len=%0d frc=%b sat=%b required 1 16 16 1 0",
               out_valid, out_sum, out_len, out_forced, out_sat);
    end
    drive(1, 8'd9, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'd9 || out_len !== 5'd1 || out_forced !== 1'b0) begin
      errors++;
      $display("FAIL forced_next: ov=%b sum=%0d len=%0d frc=%b required 1 9 1 0",
               out_valid, out_sum, out_len, out_forced);
    end
    drive(0, 8'd0, 0, 1);
  endtask

  task automatic test_backpressure();
    drive(1, 8'd225, 0, 1);
    drive(1, 8'd6, 0, 1);
    drive(1, 8'd1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'd50, 1, 0);
      checks++;
      if (got_rdy !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'd232 || out_len !== 5'd3 ||
          out_forced !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: rdy=%b ov=%b sum=%0d len=%0d required 0 1 232 3",
                 i, got_rdy, out_valid, out_sum, out_len);
      end
    end
    drive(1, 8'd50, 1, 1);
    checks++;
    if (got_rdy !== 1'b1 || out_valid !== 1'b1 || out_sum !== 16'd50 || out_len !== 5'd1) begin
      errors++;
      $display("FAIL backpressure_release: rdy=%b ov=%b sum=%0d len=%0d required 1 1 50 1",
               got_rdy, out_valid, out_sum, out_len);
    end
    drive(0, 8'd0, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 8'(k), 1, 1);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'(k) || out_len !== 5'd1) begin
        errors++;
        $display("FAIL stream[%0d]: ov=%b sum=%0d len=%0d required 1 %0d 1",
                 k, out_valid, out_sum, out_len, k);
      end
    end
    drive(0, 8'd0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_end: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_vector();
    drive(1, 8'd100, 0, 1);
    drive(1, 8'd100, 0, 1);
    in_valid = 0; in_last = 0;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 16'd0 || out_len !== 5'd0 || in_ready !== 1'b1 ||
        out_sat !== 1'b0 || out_forced !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ov=%b sum=%0d len=%0d rdy=%b required 0 0 0 1",
               out_valid, out_sum, out_len, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 8'd7, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'd7 || out_len !== 5'd1) begin
      errors++;
      $display("FAIL reset_mid_after: ov=%b sum=%0d len=%0d required 1 7 1",
               out_valid, out_sum, out_len);
    end
    drive(0, 8'd0, 0, 1);
  endtask

  task automatic test_random();
    logic v, l, r;
    logic [7:0] p;
    bit held = 0;
    v = 0; l = 0; p = 0;
    for (int n = 0; n < 600; n++) begin
      if (!held) begin
        v = ($urandom_range(0, 99) < 75);
        p = 8'($urandom_range(0, 255));
        l = ($urandom_range(0, 99) < 12);
      end
      r = ($urandom_range(0, 99) < 70);
      drive(v, p, l, r);
      held = v && !exp_rdy;
      checks++;
      if (got_rdy !== exp_rdy || out_valid !== m_ov || out_sum !== 16'(m_sum) ||
          out_len !== 5'(m_len) || out_sat !== m_sat || out_forced !== m_forced) begin
        errors++;
        $display("FAIL random[%0d]: rdy=%b ov=%b sum=%0d len=%0d sat=%b frc=%b required %b %b %0d %0d %b %b",
                 n, got_rdy, out_valid, out_sum, out_len, out_sat, out_forced,
                 exp_rdy, m_ov, m_sum, m_len, m_sat, m_forced);
      end
    end
    drive(0, 8'd0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_product = 0; in_last = 0; out_ready = 0;
    s_valid = 0; s_product = 0; s_last = 0; s_oready = 0;
    model_clear();
    #1;
    test_reset();
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    rst_n = 1'b1;
    test_normal();
    test_saturation();
    test_forced();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_vector();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Sequential stage placed directly downstream of the 4-bit Wallace tree multiplier. It accepts a stream of 8-bit partial products over a valid/ready handshake and sums each vector of products into a saturating accumulator. Each completed dot product is presented on a registered valid/ready output port. The block turns the combinational multiplier into a multiply-accumulate datapath for the filter and dot-product engines.

## Interface
- PROD_W, 8: width of each incoming product (matches the multiplier's 8-bit output).
- ACC_W, 16: accumulator and result width; must be ≥ PROD_W.
- MAX_LEN, 16: maximum terms per vector. A vector is force-closed on its MAX_LEN-th term.
- LEN_W, $clog2(MAX_LEN+1): width of the term counter and of out_len (derived; do not override).

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a product is offered.
- in_ready  out  1  block can accept a product this cycle.
- in_product  in  PROD_W  unsigned product term.
- in_last  in  1  the offered term is the final term of the vector.
- out_valid  out  1  a result is held on the out_* ports.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  unsigned vector sum, saturated.
- out_len  out  LEN_W  number of terms in the vector (1..MAX_LEN).
- out_sat  out  1  saturation occurred at any point in this vector.
- out_forced  out  1  the vector was closed by MAX_LEN, not by in_last.

## Operation
- An input beat is accepted when in_valid && in_ready.
- An output beat transfers when out_valid && out_ready.
- in_ready = !(out_valid && !out_ready). Input stalls only while a result is pending and not being taken.
- Running state: acc (ACC_W), cnt (LEN_W), sat_flag. All reset to 0.
- On an accepted beat, compute nxt = acc + zero-extended in_product, with ACC_W+1 bits internally.
  - If nxt > 2^ACC_W−1, clamp to 2^ACC_W−1 and set sat for this vector.
  - cnt_n = cnt + 1.
- Closing beat: an accepted beat with in_last = 1, or with cnt_n == MAX_LEN.
  - On a closing beat: out_sum ← clamped nxt; out_len ← cnt_n; out_sat ← sat_flag OR the current clamp; out_forced ← !in_last; out_valid ← 1.
  - acc, cnt and sat_flag clear to 0 in the same cycle.
- Non-closing beat: acc ← clamped nxt; cnt ← cnt_n; sat_flag ← sat_flag OR the current clamp.
- Output transfer without a closing beat in the same cycle: out_valid ← 0. out_* data holds its last value.
- Simultaneous output transfer and closing beat: the new result loads and out_valid stays 1. No bubble.
- Once acc has saturated, it stays at the clamp value for the rest of the vector.
- A zero-length vector cannot exist. in_last on the first term gives out_len = 1.
- Accumulation of the next vector continues while a result is pending, as long as out_ready is high.

## Timing
- Reset values: in_ready = 1; out_valid = 0; out_sum = 0; out_len = 0; out_sat = 0; out_forced = 0. Internal acc, cnt and sat_flag = 0.
- Reset is asynchronous on assertion and released synchronously to clk by the system. Reset mid-vector discards the partial sum and any pending result.
- Latency: out_valid rises on the first clk edge after the closing beat is accepted (1 cycle).
- Throughput: one term per cycle. A back-to-back sequence of single-term vectors yields one result per cycle when out_ready = 1.
- in_ready is combinational from out_valid and out_ready only. It has no dependency on in_valid.
- out_* are fully registered and stable while out_valid && !out_ready.
- Producers must hold in_product and in_last stable while in_valid && !in_ready.

## Test plan
- Normal vector: terms 225, 6, 1 with in_last on the third term, out_ready = 1. Expect one cycle later: out_sum = 232, out_len = 3, out_sat = 0, out_forced = 0.
- Saturation (ACC_W = 10): five terms of 225, in_last on the fifth. Expect out_sum = 1023, out_sat = 1, out_len = 5. The following vector 4, 4 (last) gives 8 with out_sat = 0.
- Forced close: 16 terms of 1 with in_last = 0 throughout, then a term of 9 with last. Expect first result out_sum = 16, out_len = 16, out_forced = 1. Expect second result 9, out_len = 1, out_forced = 0.
- Backpressure: result 232 pending with out_ready = 0 for 5 cycles. Expect in_ready = 0 and out_* constant. Raise out_ready together with a single-term closing beat of 50. Expect out_valid to stay 1 with out_sum = 50 on the next cycle.
- Streaming: single-term vectors 1, 2, 3, 4 on consecutive cycles with out_ready = 1. Expect results 1, 2, 3, 4 on four consecutive cycles with no gaps.
- Reset mid-vector: accept 100 and 100, assert rst_n low for 1 cycle, then send 7 with last. Expect all outputs 0 during reset, followed by out_sum = 7, out_len = 1.
